rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter sharing one resource.
- Output path is a 2-to-4 decode of a registered grant index, enabled by busy: gnt is the one-hot decode of gnt_idx while busy, 0 otherwise.
- Grants are held until the owner signals done, drops its request, or exceeds a hold limit.
- Sits in front of any shared unit (bus, memory port, ALU) in the lab designs.

---
 rtl/rr_arbiter4.sv | 75 +++++++
 tb/tb_rr_arbiter4.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant hold limit; ports clk, reset, en, req[3:0], done -> gnt[3:0], gnt_idx[1:0], busy, timeout
module rr_arbiter4 #(
  parameter int HOLD_W   = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, idx_n, w, k;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic to_n, release_c;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt_idx  <= idx_n;
      hold_cnt <= hold_n;
      timeout  <= to_n;
    end
  end
  assign busy = state == GRANT;
  assign gnt  = busy ? 4'b0001 << gnt_idx : 4'b0000;
  always_comb begin
    w = ptr;
    k = ptr;
    // scan from the farthest offset down so the nearest requester after ptr wins
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) w = k;
    end
  end
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    idx_n     = gnt_idx;
    hold_n    = hold_cnt;
    to_n      = 1'b0;
    release_c = 1'b0;
    if (state == IDLE) begin
      if (en && |req) begin
        state_n = GRANT;
        idx_n   = w;
        hold_n  = '0;
      end
    end else if (done || !req[gnt_idx]) begin
      release_c = 1'b1;
    end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
      release_c = 1'b1;
      to_n      = 1'b1;
    end else begin
      hold_n = hold_cnt + 1'b1;
    end
    if (release_c) begin
      state_n = IDLE;
      idx_n   = '0;
      hold_n  = '0;
      ptr_n   = gnt_idx + 2'd1;
    end
  end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed and random checks of rr_arbiter4 against a rule-level reference model
module tb_rr_arbiter4;
  localparam int MAX_HOLD = 15;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, done = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic busy, timeout;
  int compared = 0, mismatched = 0;
  int m_busy = 0, m_idx = 0, m_ptr = 0, m_hold = 0, m_to = 0;

  rr_arbiter4 #(.HOLD_W(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_release(input int forced);
    m_ptr  = (m_idx + 1) % 4;
    m_busy = 0;
    m_idx  = 0;
    m_hold = 0;
    m_to   = forced;
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic d);
    logic [3:0] exp_gnt;
    reset = r; en = e; req = rq; done = d;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (m_busy == 0) begin
      m_to = 0;
      if (e && rq != 0) begin
        for (int o = 3; o >= 0; o--)
          if (rq[(m_ptr + o) % 4]) m_idx = (m_ptr + o) % 4;
        m_busy = 1;
        m_hold = 0;
      end
    end else if (d || !rq[m_idx]) model_release(0);
    else if (m_hold == MAX_HOLD - 1) model_release(1);
    else begin
      m_hold++;
      m_to = 0;
    end
    #1;
    exp_gnt = m_busy != 0 ? 4'(1 << m_idx) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [3:0] rq;
    logic r, e, d;
    step(1, 0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    step(0, 1, 4'b0101, 0);
    chk("first_gnt", 32'(gnt), 32'b0001);
    step(0, 1, 4'b0101, 1);
    chk("rel_gnt", 32'(gnt), 32'd0);
    step(0, 1, 4'b0101, 0);
    chk("second_gnt", 32'(gnt), 32'b0100);
    step(0, 1, 4'b0101, 1);
    step(1, 0, 4'b0000, 0);
    for (int n = 0; n < 5; n++) begin
      step(0, 1, 4'b1111, 0);
      chk("rr_idx", 32'(gnt_idx), 32'(n % 4));
      step(0, 1, 4'b1111, 1);
      chk("rr_idle", 32'(busy), 32'd0);
    end
    step(1, 0, 4'b0000, 0);
    cnt = 0;
    step(0, 1, 4'b0010, 0);
    while (busy && cnt < 40) begin
      cnt++;
      step(0, 1, 4'b0010, 0);
    end
    chk("hold_len", 32'(cnt), 32'(MAX_HOLD));
    chk("timeout_pulse", 32'(timeout), 32'd1);
    step(0, 1, 4'b0010, 0);
    chk("regrant_idx", 32'(gnt_idx), 32'd1);
    chk("timeout_clear", 32'(timeout), 32'd0);
    step(0, 1, 4'b0000, 0);
    chk("drop_rel", 32'(busy), 32'd0);
    step(0, 1, 4'b0010, 0);
    step(0, 0, 4'b0010, 0);
    chk("en0_hold", 32'(busy), 32'd1);
    step(0, 0, 4'b0010, 1);
    for (int n = 0; n < 3; n++) step(0, 0, 4'b1000, 0);
    chk("en0_nogrant", 32'(busy), 32'd0);
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b0001, 0);
    for (int n = 0; n < MAX_HOLD - 1; n++) step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0001, 1);
    chk("done_at_limit_to", 32'(timeout), 32'd0);
    chk("done_at_limit_busy", 32'(busy), 32'd0);
    step(0, 1, 4'b1111, 0);
    step(1, 1, 4'b1111, 0);
    chk("midreset_gnt", 32'(gnt), 32'd0);
    step(0, 1, 4'b1111, 0);
    chk("post_reset_idx", 32'(gnt_idx), 32'd0);
    rq = 4'b1111;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) rq = 4'($urandom_range(15));
      d = $urandom_range(9) == 0;
      e = $urandom_range(3) != 0;
      r = $urandom_range(63) == 0;
      step(r, e, rq, d);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
